// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcodes and condition-flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b110;
    localparam logic [2:0] OP_SUB = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/flag_stack.sv
`default_nettype none
// ============================================================================
// Module      : flag_stack
// Description : DEPTH-entry LIFO for condition flags, top entry always at slot 0.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_stack #(
    parameter int DEPTH = 4,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          err
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] c_full_ptr = PW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic          r_full;
    logic          r_empty;
    logic          r_err;
    logic          w_err;
    logic          w_do_push;
    logic          w_do_pop;

    always_comb begin
        w_err     = (push && pop) || (push && r_full) || (pop && r_empty);
        w_do_push = push && !pop && !r_full;
        w_do_pop  = pop && !push && !r_empty;
        w_ptr_nxt = r_ptr;
        if (w_do_push)
            w_ptr_nxt = r_ptr + 1'b1;
        else if (w_do_pop)
            w_ptr_nxt = r_ptr - 1'b1;
    end

    // Shift-register organisation keeps the top of stack at a fixed slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_full  <= (w_ptr_nxt == c_full_ptr);
            r_empty <= (w_ptr_nxt == '0);
            r_err   <= w_err;
            if (w_do_push) begin
                r_mem[0] <= din;
                for (int i = 1; i < DEPTH; i++)
                    r_mem[i] <= r_mem[i-1];
            end else if (w_do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++)
                    r_mem[i] <= r_mem[i+1];
                r_mem[DEPTH-1] <= '0;
            end
        end
    end

    assign dout  = r_mem[0];
    assign full  = r_full;
    assign empty = r_empty;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: rtl/cal_flags_seq.sv
`default_nettype none
// ============================================================================
// Module      : cal_flags_seq
// Description : Registered ALU condition flags with sticky overflow and save stack.
// Revision    : 1.0 - initial release
// ============================================================================
module cal_flags_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             co_add,
    input  logic             co_sub,
    input  logic             clr_sticky,
    input  logic             push,
    input  logic             pop,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             vs,
    output logic             out_valid,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    flags_t r_flags;
    flags_t w_flags;
    flags_t w_stk_dout;
    logic   r_vs;
    logic   r_out_valid;
    logic   w_is_add;
    logic   w_is_sub;
    logic   w_sa;
    logic   w_sb;
    logic   w_sr;
    logic   w_pop_ok;
    logic   w_unused;

    assign w_unused = ^{a[WIDTH-2:0], b[WIDTH-2:0]};

    always_comb begin
        w_is_add = (op == OP_ADD);
        w_is_sub = (op == OP_SUB);
        w_sa     = a[WIDTH-1];
        w_sb     = b[WIDTH-1];
        w_sr     = result[WIDTH-1];
        w_flags         = '0;
        w_flags[FLAG_N] = w_sr;
        w_flags[FLAG_Z] = (result == '0);
        if (w_is_add) begin
            w_flags[FLAG_C] = co_add;
            w_flags[FLAG_V] = (w_sa == w_sb) && (w_sr != w_sa);
        end else if (w_is_sub) begin
            w_flags[FLAG_C] = co_sub;
            w_flags[FLAG_V] = (w_sa != w_sb) && (w_sr != w_sa);
        end
    end

    // Mirrors the stack's own acceptance rule: a pop only lands when it is legal.
    assign w_pop_ok = pop && !push && !stk_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags     <= 4'b0010;
            r_vs        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_flags     <= w_stk_dout;
                r_out_valid <= 1'b0;
            end else if (in_valid) begin
                r_flags     <= w_flags;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end

            if (in_valid && !w_pop_ok && w_flags[FLAG_V])
                r_vs <= 1'b1;
            else if (clr_sticky)
                r_vs <= 1'b0;
        end
    end

    flag_stack #(
        .DEPTH (DEPTH),
        .DW    (4)
    ) u_flag_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (r_flags),
        .dout    (w_stk_dout),
        .full    (stk_full),
        .empty   (stk_empty),
        .err     (stk_err)
    );

    assign c         = r_flags[FLAG_C];
    assign n         = r_flags[FLAG_N];
    assign z         = r_flags[FLAG_Z];
    assign v         = r_flags[FLAG_V];
    assign vs        = r_vs;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
